// File: rtl/vadd_pkg.sv
// rtl/vadd_pkg.sv - shared types, constants and helpers for the vector add chunk sequencer
package vadd_pkg;

  localparam int DATA_WIDTH      = 64;
  localparam int SEW_WIDTH       = 2;
  localparam int OPSEL_WIDTH     = 6;
  localparam int VL_WIDTH        = 11;
  localparam int LANE_BITS       = 10;
  localparam int BYTES_PER_CHUNK = 8;
  localparam int RESULT_WIDTH    = DATA_WIDTH + 17;

  localparam logic [SEW_WIDTH-1:0] SEW_8  = 2'd0;
  localparam logic [SEW_WIDTH-1:0] SEW_16 = 2'd1;
  localparam logic [SEW_WIDTH-1:0] SEW_32 = 2'd2;
  localparam logic [SEW_WIDTH-1:0] SEW_64 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Elements per 64-bit chunk for a given element-width code.
  function automatic logic [3:0] elems_per_chunk(input logic [SEW_WIDTH-1:0] sew);
    return 4'd8 >> sew;
  endfunction

  // ceil(vl / epc); epc is a power of two so this is a round-up shift.
  function automatic logic [VL_WIDTH-1:0] chunk_count(input logic [VL_WIDTH-1:0] vl,
                                                      input logic [SEW_WIDTH-1:0] sew);
    logic [VL_WIDTH-1:0]  sum;
    logic [SEW_WIDTH-1:0] shift;
    sum   = vl + VL_WIDTH'(elems_per_chunk(sew) - 4'd1);
    shift = 2'd3 - sew;
    return sum >> shift;
  endfunction

  // Byte enables of the final chunk: a full chunk when vl divides evenly,
  // otherwise only the bytes covered by the remaining elements.
  function automatic logic [7:0] sew_tail_byte_en(input logic [VL_WIDTH-1:0] vl,
                                                  input logic [SEW_WIDTH-1:0] sew);
    logic [VL_WIDTH-1:0] rem;
    logic [3:0]          nbytes;
    logic [7:0]          mask;
    rem    = vl & VL_WIDTH'(elems_per_chunk(sew) - 4'd1);
    nbytes = 4'(rem[3:0] << sew);
    mask   = 8'((8'd1 << nbytes) - 8'd1);
    return (rem == '0) ? 8'hFF : mask;
  endfunction

endpackage

// File: rtl/vadd_chunk_seq_if.sv
// rtl/vadd_chunk_seq_if.sv - request, operand, adder and result bundle of the chunk sequencer
interface vadd_chunk_seq_if;
  import vadd_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [VL_WIDTH-1:0]     req_vl;
  logic [SEW_WIDTH-1:0]    req_sew;
  logic [OPSEL_WIDTH-1:0]  req_opsel;
  logic                    req_carry;

  logic                    op_valid;
  logic                    op_ready;
  logic [DATA_WIDTH-1:0]   op_vec0;
  logic [DATA_WIDTH-1:0]   op_vec1;

  logic [DATA_WIDTH-1:0]   add_vec0;
  logic [DATA_WIDTH-1:0]   add_vec1;
  logic                    add_carry;
  logic [SEW_WIDTH-1:0]    add_sew;
  logic [OPSEL_WIDTH-1:0]  add_opsel;
  logic [RESULT_WIDTH-1:0] add_result;

  logic                    res_valid;
  logic                    res_ready;
  logic [DATA_WIDTH-1:0]   res_data;
  logic [7:0]              res_guard;
  logic [7:0]              res_byte_en;
  logic                    res_last;
  logic                    done;

  // Sequencer side.
  modport master (
    input  req_valid, req_vl, req_sew, req_opsel, req_carry,
    output req_ready,
    input  op_valid, op_vec0, op_vec1,
    output op_ready,
    output add_vec0, add_vec1, add_carry, add_sew, add_opsel,
    input  add_result,
    output res_valid, res_data, res_guard, res_byte_en, res_last,
    input  res_ready,
    output done
  );

  // Environment side: register-read stage, shared adder and writeback.
  modport slave (
    output req_valid, req_vl, req_sew, req_opsel, req_carry,
    input  req_ready,
    output op_valid, op_vec0, op_vec1,
    input  op_ready,
    input  add_vec0, add_vec1, add_carry, add_sew, add_opsel,
    output add_result,
    input  res_valid, res_data, res_guard, res_byte_en, res_last,
    output res_ready,
    input  done
  );

endinterface

// File: rtl/vadd_result_unpack.sv
// rtl/vadd_result_unpack.sv - extracts 64 data bits and 8 guard bits from the 81-bit guarded adder result
module vadd_result_unpack
  import vadd_pkg::*;
(
  input  logic [RESULT_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [7:0]              guard
);

  // Each byte lane occupies LANE_BITS bits: slot 0 is a carry-propagate
  // separator, slots 1..8 are the sum byte, slot 9 is the byte's guard.
  // The separators (every 10th bit, including bit 80) carry no data.
  logic unused_separators;

  // Pick data and guard bits out of every lane.
  always_comb begin
    data  = '0;
    guard = '0;
    for (int i = 0; i < BYTES_PER_CHUNK; i++) begin
      data[8*i +: 8] = result[LANE_BITS*i + 1 +: 8];
      guard[i]       = result[LANE_BITS*i + 9];
    end
  end

  assign unused_separators = ^{result[80], result[70], result[60], result[50],
                               result[40], result[30], result[20], result[10], result[0]};

endmodule

// File: rtl/vadd_chunk_seq.sv
// rtl/vadd_chunk_seq.sv - streams one vector add/sub instruction through the shared SIMD adder in 64-bit chunks
module vadd_chunk_seq
  import vadd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  vadd_chunk_seq_if.master bus
);

  state_t                 state_q, state_d;

  logic [VL_WIDTH-1:0]    vl_q;
  logic [SEW_WIDTH-1:0]   sew_q;
  logic [OPSEL_WIDTH-1:0] opsel_q;
  logic                   carry_q;
  logic [VL_WIDTH-1:0]    chunk_cnt_q;

  logic [VL_WIDTH-1:0]    nchunks;
  logic [7:0]             tail_be;
  logic                   last_chunk;

  logic                   req_ready_c;
  logic                   op_ready_c;
  logic                   accept;
  logic                   retire;
  logic                   op_hs;
  logic                   res_hs;

  logic                   res_valid_q;
  logic [DATA_WIDTH-1:0]  res_data_q;
  logic [7:0]             res_guard_q;
  logic [7:0]             res_be_q;
  logic                   res_last_q;
  logic                   done_q;

  logic [DATA_WIDTH-1:0]  unp_data;
  logic [7:0]             unp_guard;

  // Chunk geometry derived from the latched request; stable for the whole instruction.
  assign nchunks    = chunk_count(vl_q, sew_q);
  assign tail_be    = sew_tail_byte_en(vl_q, sew_q);
  assign last_chunk = (chunk_cnt_q == nchunks - VL_WIDTH'(1));

  assign op_hs  = bus.op_valid && op_ready_c;
  assign res_hs = res_valid_q && bus.res_ready;

  // Next state and handshake readiness; operands flow only when the output slot is free or draining.
  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    op_ready_c  = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (bus.req_vl != '0) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        op_ready_c = !res_valid_q || bus.res_ready;
        if (bus.op_valid && op_ready_c && last_chunk) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (res_hs) begin
          state_d = IDLE;
          retire  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the instruction fields at acceptance; they configure the adder until retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      vl_q    <= '0;
      sew_q   <= '0;
      opsel_q <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      vl_q    <= bus.req_vl;
      sew_q   <= bus.req_sew;
      opsel_q <= bus.req_opsel;
      carry_q <= bus.req_carry;
    end
  end

  // Count accepted operand chunks within the current instruction.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      chunk_cnt_q <= '0;
    end else if (op_hs) begin
      chunk_cnt_q <= chunk_cnt_q + VL_WIDTH'(1);
    end
  end

  vadd_result_unpack u_unpack (
    .result (bus.add_result),
    .data   (unp_data),
    .guard  (unp_guard)
  );

  // Output register: a new operand reloads it even while the old result leaves, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_guard_q <= '0;
      res_be_q    <= '0;
      res_last_q  <= 1'b0;
    end else if (op_hs) begin
      res_valid_q <= 1'b1;
      res_data_q  <= unp_data;
      res_guard_q <= unp_guard;
      res_be_q    <= last_chunk ? tail_be : 8'hFF;
      res_last_q  <= last_chunk;
    end else if (res_hs) begin
      res_valid_q <= 1'b0;
    end
  end

  // Retirement pulse: after the last result leaves, or right after a zero-length request.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (accept && (bus.req_vl == '0)) || retire;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.op_ready    = op_ready_c;
  assign bus.add_vec0    = bus.op_vec0;
  assign bus.add_vec1    = bus.op_vec1;
  assign bus.add_carry   = carry_q;
  assign bus.add_sew     = sew_q;
  assign bus.add_opsel   = opsel_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_guard   = res_guard_q;
  assign bus.res_byte_en = res_be_q;
  assign bus.res_last    = res_last_q;
  assign bus.done        = done_q;

endmodule
